// File: rtl/line_clear_engine.sv
// line_clear_engine: deletes full board rows, shifts survivors down and zero-fills the vacated top rows
module line_clear_engine #(
  parameter int ROWS = 30,
  parameter int COLS = 10,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] LINES_CLEARED,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_RE,
  input  logic [31:0]       RAM_RDATA,
  output logic              RAM_WE,
  output logic [31:0]       RAM_WDATA
);
  typedef enum logic [2:0] {IDLE, READ, EVAL, WRITE, FILL, DONE_ST} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(ROWS);
  state_t state, state_n;
  logic [ADDR_W-1:0] rd, rd_n, wr, wr_n, cnt, cnt_n, lc_n, addr_n;
  logic [31:0] rowbuf, rowbuf_n, wdata_n;
  logic re_n, we_n, busy_n, full;
  // a row is full when every playfield cell is non-zero; bits above the playfield are ignored
  always_comb begin
    full = 1'b1;
    for (int c = 0; c < COLS; c++) full = full & (|RAM_RDATA[2*c +: 2]);
  end
  // next state and pointers; outputs are derived from the next state so they can be registered
  always_comb begin
    state_n = state;
    rd_n = rd;
    wr_n = wr;
    cnt_n = cnt;
    rowbuf_n = rowbuf;
    lc_n = LINES_CLEARED;
    case (state)
      IDLE: if (START) begin
        state_n = READ;
        rd_n = LAST;
        wr_n = LAST;
        cnt_n = '0;
        lc_n = '0;
      end
      READ: state_n = EVAL;
      EVAL: begin
        rowbuf_n = RAM_RDATA;
        if (full) begin
          cnt_n = cnt == MAX_CNT ? cnt : cnt + 1'b1;
          state_n = rd == '0 ? FILL : READ;
          rd_n = rd == '0 ? rd : rd - 1'b1;
        end else if (rd != wr) begin
          state_n = WRITE;
        end else if (rd == '0) begin
          state_n = DONE_ST;
        end else begin
          state_n = READ;
          rd_n = rd - 1'b1;
          wr_n = wr - 1'b1;
        end
      end
      WRITE: begin
        wr_n = wr - 1'b1;
        state_n = rd == '0 ? FILL : READ;
        rd_n = rd == '0 ? rd : rd - 1'b1;
      end
      FILL: begin
        state_n = wr == '0 ? DONE_ST : FILL;
        wr_n = wr == '0 ? wr : wr - 1'b1;
      end
      DONE_ST: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    lc_n = state_n == DONE_ST ? cnt_n : lc_n;
    re_n = state_n == READ;
    we_n = state_n == WRITE || state_n == FILL;
    busy_n = state_n != IDLE && state_n != DONE_ST;
    addr_n = re_n ? rd_n : we_n ? wr_n : '0;
    wdata_n = state_n == WRITE ? rowbuf_n : '0;
  end
  // state, pointers and registered outputs; reset abandons any run in progress
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      rowbuf <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      LINES_CLEARED <= '0;
      RAM_ADDR <= '0;
      RAM_RE <= 1'b0;
      RAM_WE <= 1'b0;
      RAM_WDATA <= '0;
    end else begin
      state <= state_n;
      rd <= rd_n;
      wr <= wr_n;
      cnt <= cnt_n;
      rowbuf <= rowbuf_n;
      BUSY <= busy_n;
      DONE <= state_n == DONE_ST;
      LINES_CLEARED <= lc_n;
      RAM_ADDR <= addr_n;
      RAM_RE <= re_n;
      RAM_WE <= we_n;
      RAM_WDATA <= wdata_n;
    end
  end
endmodule

// File: tb/tb_line_clear_engine.sv
// tb_line_clear_engine: randomized and directed boards checked against a row-filtering model
module tb_line_clear_engine;
  localparam int ROWS = 30;
  logic CLK = 0, RESET = 1, START = 0, load = 0;
  logic BUSY, DONE, RAM_RE, RAM_WE;
  logic [4:0] LINES_CLEARED, RAM_ADDR;
  logic [31:0] RAM_RDATA = 0, RAM_WDATA;
  logic [31:0] mem [32];
  logic [31:0] board [32];
  logic [31:0] expb [32];
  int pass = 0, total = 0, cyc = 0, exp_done = 0, ecnt = 0, emov = 0, wcount = 0, done_cyc = 0;
  bit armed = 0, finished = 0;

  line_clear_engine dut (.CLK(CLK), .RESET(RESET), .START(START), .BUSY(BUSY), .DONE(DONE),
    .LINES_CLEARED(LINES_CLEARED), .RAM_ADDR(RAM_ADDR), .RAM_RE(RAM_RE), .RAM_RDATA(RAM_RDATA),
    .RAM_WE(RAM_WE), .RAM_WDATA(RAM_WDATA));

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (load) for (int i = 0; i < 32; i++) mem[i] <= board[i];
    else if (RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
    if (RAM_RE) RAM_RDATA <= mem[RAM_ADDR];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic bit is_full(input logic [31:0] r);
    for (int c = 0; c < 10; c++) if (r[2*c +: 2] == 2'b00) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] rand_row(input bit f);
    logic [31:0] r;
    int k;
    r = $urandom;
    for (int c = 0; c < 10; c++) r[2*c +: 2] = f ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
    k = $urandom_range(0, 9);
    if (!f) r[2*k +: 2] = 2'b00;
    return r;
  endfunction

  task automatic model();
    int k;
    k = ROWS - 1;
    ecnt = 0;
    emov = 0;
    for (int i = 0; i < 32; i++) expb[i] = i < ROWS ? 32'h0 : board[i];
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (is_full(board[r])) ecnt++;
      else begin
        expb[k] = board[r];
        if (k != r) emov++;
        k--;
      end
    end
    exp_done = 2 * ROWS + emov + ecnt + 1;
  endtask

  task automatic clear_board();
    for (int i = 0; i < 32; i++) board[i] = 0;
  endtask

  always @(negedge CLK) if (armed) begin
    cyc++;
    chk("busy", BUSY, cyc < exp_done);
    chk("done", DONE, cyc == exp_done);
    chk("re_we_excl", RAM_RE & RAM_WE, 0);
    if (RAM_WE) wcount++;
    if (DONE && done_cyc == 0) done_cyc = cyc;
    if (cyc == exp_done) begin
      chk("lines_cleared", LINES_CLEARED, ecnt);
      armed = 0;
      finished = 1;
    end
  end

  task automatic run(input bit poke);
    model();
    @(negedge CLK) load = 1;
    @(negedge CLK) load = 0;
    wcount = 0;
    finished = 0;
    done_cyc = 0;
    START = 1;
    @(posedge CLK);
    #1 START = 0;
    cyc = 0;
    armed = 1;
    for (int i = 0; i < 400 && !finished; i++) begin
      @(negedge CLK);
      START = poke && i == 8;
    end
    START = 0;
    armed = 0;
    chk("done_seen", finished, 1);
    for (int i = 0; i < 32; i++) chk($sformatf("row%0d", i), mem[i], expb[i]);
    chk("write_count", wcount, emov + ecnt);
    repeat (4) begin
      @(negedge CLK);
      chk("idle_after", {BUSY, DONE}, 0);
    end
  endtask

  initial begin
    int dcount;
    bit seen;
    clear_board();
    repeat (2) @(negedge CLK);
    chk("rst_ctrl", {BUSY, DONE, RAM_RE, RAM_WE, LINES_CLEARED, RAM_ADDR}, 0);
    chk("rst_wdata", RAM_WDATA, 0);
    RESET = 0;
    run(0);
    chk("empty_done_cycle", done_cyc, 61);
    chk("empty_writes", wcount, 0);
    chk("empty_lc", LINES_CLEARED, 0);
    clear_board();
    board[29] = 32'h000FFFFF;
    board[28] = 32'h00000005;
    run(0);
    chk("c2_row29", mem[29], 32'h5);
    chk("c2_row28", mem[28], 0);
    chk("c2_row0", mem[0], 0);
    chk("c2_lc", LINES_CLEARED, 1);
    clear_board();
    for (int r = 26; r < 30; r++) board[r] = 32'h000FFFFF;
    board[25] = 32'hABC00001;
    for (int r = 0; r < 4; r++) board[r] = 32'h00000100;
    run(0);
    chk("c3_row29", mem[29], 32'hABC00001);
    chk("c3_row3", mem[3], 0);
    chk("c3_row0", mem[0], 0);
    chk("c3_lc", LINES_CLEARED, 4);
    clear_board();
    board[29] = 32'h000FFFFF;
    board[27] = 32'h000AAAAA;
    board[28] = 32'h00000011;
    board[26] = 32'h00000022;
    run(0);
    chk("c4_row29", mem[29], 32'h11);
    chk("c4_row28", mem[28], 32'h22);
    chk("c4_lc", LINES_CLEARED, 2);
    for (int r = 1; r < ROWS; r++) board[r] = rand_row(0);
    board[0] = 32'hF00FFFFF;
    run(0);
    chk("c5_writes", wcount, 1);
    chk("c5_row0", mem[0], 0);
    chk("c5_lc", LINES_CLEARED, 1);
    for (int r = 0; r < ROWS; r++) board[r] = rand_row(1);
    run(0);
    chk("all_full_lc", LINES_CLEARED, 30);
    chk("all_full_cycle", done_cyc, 91);
    chk("all_full_row29", mem[29], 0);
    for (int t = 0; t < 40; t++) begin
      int dens;
      dens = $urandom_range(1, 8);
      for (int r = 0; r < ROWS; r++) begin
        int p;
        p = $urandom_range(0, 9);
        board[r] = p < dens ? rand_row(1) : p == 9 ? 32'h0 : rand_row(0);
      end
      run(t % 4 == 1);
    end
    clear_board();
    for (int r = 26; r < 30; r++) board[r] = 32'hFFFFFFFF;
    board[25] = 32'h12300002;
    @(negedge CLK) load = 1;
    @(negedge CLK) load = 0;
    START = 1;
    @(posedge CLK);
    #1 START = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      seen = RAM_WE;
    end
    chk("write_reached", seen, 1);
    RESET = 1;
    @(negedge CLK);
    chk("midrst_ctrl", {BUSY, DONE, RAM_RE, RAM_WE, LINES_CLEARED, RAM_ADDR}, 0);
    chk("midrst_wdata", RAM_WDATA, 0);
    RESET = 0;
    dcount = 0;
    repeat (80) begin
      @(negedge CLK);
      if (DONE || BUSY) dcount++;
    end
    chk("no_done_after_rst", dcount, 0);
    RESET = 1;
    START = 1;
    @(negedge CLK);
    RESET = 0;
    START = 0;
    @(negedge CLK);
    chk("start_rst_busy", {BUSY, RAM_RE}, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
